truth_table_sweeper: RTL

- Synthesizable upstream stimulus/capture stage for the lab's 3-input combinational circuits (inputs A, B, C; output Y).
- Drives {A,B,C} through all 8 combinations in ascending order (A = MSB), holding each for HOLD_CYCLES clocks.
- Samples Y at the end of each hold, builds an 8-bit truth table, compares it against a latched expected table, and reports pass plus mismatch count.
- Replaces hand-written delay-based stimulus for on-board or regression checking of lab circuits.

---
 rtl/ddco_pkg.sv | 19 +
 rtl/truth_table_sweeper_if.sv | 32 +++
 rtl/truth_table_sweeper_popcount8.sv | 20 ++
 rtl/truth_table_sweeper.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ddco_pkg.sv
// Shared definitions for the lab stimulus/capture checkers.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package ddco_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;
    localparam int MISMATCH_W  = 4;

    // Sweep FSM encoding, kept as plain constants so older tools and
    // netlists see a fixed 2-bit state register.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRIVE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle between a truth-table sweeper and its controller / circuit under test.
// Latency: none (wires only).
// Backpressure: none; start is a single-cycle request with no handshake.
//   slave  : sweeper side (takes start/abort/expected/y, drives abc and results)
//   master : controller side (drives start/abort/expected/y, observes results)
interface truth_table_sweeper_if;
    import ddco_pkg::*;

    logic                   start;
    logic                   abort;
    logic [NUM_VECTORS-1:0] expected;
    logic                   y;
    logic                   a;
    logic                   b;
    logic                   c;
    logic                   busy;
    logic                   done;
    logic [NUM_VECTORS-1:0] table_out;
    logic                   pass;
    logic [MISMATCH_W-1:0]  mismatch_cnt;

    modport slave (
        input  start, abort, expected, y,
        output a, b, c, busy, done, table_out, pass, mismatch_cnt
    );

    modport master (
        output start, abort, expected, y,
        input  a, b, c, busy, done, table_out, pass, mismatch_cnt
    );

endinterface

// File: rtl/truth_table_sweeper_popcount8.sv
// Counts the set bits of an 8-bit word (0..8).
// Latency: combinational, zero cycles.
// Backpressure: none.
//   vec_i : word to count
//   cnt_o : number of ones in vec_i
module popcount8
    import ddco_pkg::*;
(
    input  logic [NUM_VECTORS-1:0] vec_i,
    output logic [MISMATCH_W-1:0]  cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            cnt_o = cnt_o + {{(MISMATCH_W-1){1'b0}}, vec_i[i]};
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps {a,b,c} through 0..7, samples y at the end of each hold, and grades the table.
// Latency: done rises 8*HOLD_CYCLES clocks after the edge that accepts start.
// Backpressure: start is accepted only in IDLE/DONE; abort wins over start while sweeping.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus.start/abort/expected/y : sweep control, reference table, circuit output
//   bus.a/b/c : circuit inputs (current vector index, a = MSB)
//   bus.busy/done/table_out/pass/mismatch_cnt : status and results (all registered)
module truth_table_sweeper
    import ddco_pkg::*;
#(
    parameter int HOLD_CYCLES = 20,
    parameter int HOLD_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_sweeper_if.slave bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t                 state_q,    state_d;
    logic [VEC_W-1:0]       idx_q,      idx_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [NUM_VECTORS-1:0] table_q,    table_d;
    logic [NUM_VECTORS-1:0] expected_q, expected_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic                   pass_q,     pass_d;
    logic [MISMATCH_W-1:0]  mm_cnt_q,   mm_cnt_d;

    // Table as it will be after the current edge's capture; grading on the
    // final edge must include the bit being written on that same edge.
    logic [NUM_VECTORS-1:0] table_capt;
    logic [MISMATCH_W-1:0]  mm_cnt_capt;

    always_comb begin
        table_capt        = table_q;
        table_capt[idx_q] = bus.y;
    end

    popcount8 u_popcount (
        .vec_i (table_capt ^ expected_q),
        .cnt_o (mm_cnt_capt)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        table_d    = table_q;
        expected_d = expected_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        mm_cnt_d   = mm_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d    = ST_DRIVE;
                    idx_d      = '0;
                    hold_cnt_d = '0;
                    table_d    = '0;
                    expected_d = bus.expected;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    mm_cnt_d   = '0;
                end
            end
            ST_DRIVE: begin
                if (bus.abort) begin
                    // Partial table is left visible for debug.
                    state_d    = ST_IDLE;
                    idx_d      = '0;
                    hold_cnt_d = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    mm_cnt_d   = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    table_d    = table_capt;
                    hold_cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d  = ST_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        pass_d   = (table_capt == expected_q);
                        mm_cnt_d = mm_cnt_capt;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                idx_d      = '0;
                hold_cnt_d = '0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            table_q    <= '0;
            expected_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mm_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            table_q    <= table_d;
            expected_q <= expected_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            mm_cnt_q   <= mm_cnt_d;
        end
    end

    assign bus.a            = idx_q[2];
    assign bus.b            = idx_q[1];
    assign bus.c            = idx_q[0];
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.table_out    = table_q;
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = mm_cnt_q;

endmodule
